// File: rtl/riviera_pkg.sv
// Shared load/store definitions: access-unit encoding, load FSM states and the
// alignment rule used by both the load and store paths.
package riviera_pkg;

  typedef enum logic [1:0] {
    B  = 2'd0,
    HW = 2'd1,
    W  = 2'd2,
    DW = 2'd3
  } mem_unit_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_ERR   = 3'd4,
    ST_REQ2  = 3'd5,
    ST_WAIT2 = 3'd6
  } ld_state_t;

  // True exactly when the access would run past the end of its 8-byte line.
  function automatic logic is_misaligned(input mem_unit_t unit, input logic [2:0] off);
    case (unit)
      HW:      return off == 3'd7;
      W:       return off >= 3'd5;
      DW:      return off != 3'd0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_load_extender.sv
// Combinational field extract + sign/zero extend of a load from one or two
// consecutive 64-bit DM lines.
module dm_load_extender
  import riviera_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [63:0]     line_lo,
  input  logic [63:0]     line_hi,
  input  logic [2:0]      off,
  input  mem_unit_t       unit,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] result
);

  logic [63:0] f;

  assign f = 64'({line_hi, line_lo} >> {off, 3'b000});

  always_comb begin
    result = '0;
    case (unit)
      B:       result = {{(XLEN-8){~is_unsigned & f[7]}}, f[7:0]};
      HW:      result = {{(XLEN-16){~is_unsigned & f[15]}}, f[15:0]};
      W:       result = {{(XLEN-32){~is_unsigned & f[31]}}, f[31:0]};
      default: result = XLEN'(f);
    endcase
  end

endmodule

// File: rtl/dm_load_controller.sv
// MEM-stage load controller: one load per transaction over a req/gnt + rvalid DM port.
// MISALIGNED_SPLIT_EN: line-crossing loads are split into two line reads instead of ERR.
module dm_load_controller
  import riviera_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ld_valid,
  output logic              o_ld_ready,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [1:0]        i_ld_unit,
  input  logic              i_ld_unsigned,
  input  logic [REG_W-1:0]  i_ld_rd,
  output logic              o_dm_req,
  output logic [ADDR_W-1:0] o_dm_addr,
  input  logic              i_dm_gnt,
  input  logic              i_dm_rvalid,
  input  logic [63:0]       i_dm_rdata,
  output logic              o_wb_valid,
  output logic [XLEN-1:0]   o_wb_data,
  output logic [REG_W-1:0]  o_wb_rd,
  output logic              o_staller,
  output logic              o_miss_aligned_error
);

  ld_state_t        state;
  logic [2:0]       off_q;
  mem_unit_t        unit_q;
  logic             uns_q;
  logic [REG_W-1:0] rd_q;
  logic [63:0]      ext_lo, ext_hi;
  logic [XLEN-1:0]  ext_data;
  logic             accept, misal;

  assign o_ld_ready = (state == ST_IDLE);
  assign o_staller  = (state != ST_IDLE) | i_ld_valid;
  assign accept     = i_ld_valid & o_ld_ready;
  assign misal      = is_misaligned(mem_unit_t'(i_ld_unit), i_ld_addr[2:0]);

`ifdef MISALIGNED_SPLIT_EN
  logic [63:0] line0_q;
  logic        split_q;

  // The second read returns the upper line; the first one is already latched.
  assign ext_lo = (state == ST_WAIT2) ? line0_q : i_dm_rdata;
  assign ext_hi = (state == ST_WAIT2) ? i_dm_rdata : 64'd0;
  assign o_miss_aligned_error = 1'b0;
`else
  logic err_q;

  assign ext_lo = i_dm_rdata;
  assign ext_hi = 64'd0;
  assign o_miss_aligned_error = err_q;
`endif

  dm_load_extender #(.XLEN(XLEN)) u_ext (
    .line_lo     (ext_lo),
    .line_hi     (ext_hi),
    .off         (off_q),
    .unit        (unit_q),
    .is_unsigned (uns_q),
    .result      (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      off_q      <= '0;
      unit_q     <= B;
      uns_q      <= 1'b0;
      rd_q       <= '0;
      o_dm_req   <= 1'b0;
      o_dm_addr  <= '0;
      o_wb_valid <= 1'b0;
      o_wb_data  <= '0;
      o_wb_rd    <= '0;
`ifdef MISALIGNED_SPLIT_EN
      line0_q    <= '0;
      split_q    <= 1'b0;
`else
      err_q      <= 1'b0;
`endif
    end else begin
      o_wb_valid <= 1'b0;
`ifndef MISALIGNED_SPLIT_EN
      err_q      <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (accept) begin
            off_q  <= i_ld_addr[2:0];
            unit_q <= mem_unit_t'(i_ld_unit);
            uns_q  <= i_ld_unsigned;
            rd_q   <= i_ld_rd;
`ifdef MISALIGNED_SPLIT_EN
            split_q   <= misal;
            state     <= ST_REQ;
            o_dm_req  <= 1'b1;
            o_dm_addr <= {i_ld_addr[ADDR_W-1:3], 3'b000};
`else
            if (misal) begin
              state <= ST_ERR;
              err_q <= 1'b1;
            end else begin
              state     <= ST_REQ;
              o_dm_req  <= 1'b1;
              o_dm_addr <= {i_ld_addr[ADDR_W-1:3], 3'b000};
            end
`endif
          end
        end
        ST_REQ: begin
          if (i_dm_gnt) begin
            o_dm_req <= 1'b0;
            state    <= ST_WAIT;
          end
        end
`ifdef MISALIGNED_SPLIT_EN
        ST_WAIT: begin
          if (i_dm_rvalid) begin
            if (split_q) begin
              line0_q   <= i_dm_rdata;
              o_dm_addr <= o_dm_addr + ADDR_W'(8);
              o_dm_req  <= 1'b1;
              state     <= ST_REQ2;
            end else begin
              o_wb_valid <= 1'b1;
              o_wb_data  <= ext_data;
              o_wb_rd    <= rd_q;
              state      <= ST_RESP;
            end
          end
        end
        ST_REQ2: begin
          if (i_dm_gnt) begin
            o_dm_req <= 1'b0;
            state    <= ST_WAIT2;
          end
        end
        ST_WAIT2: begin
          if (i_dm_rvalid) begin
            o_wb_valid <= 1'b1;
            o_wb_data  <= ext_data;
            o_wb_rd    <= rd_q;
            state      <= ST_RESP;
          end
        end
`else
        ST_WAIT: begin
          if (i_dm_rvalid) begin
            o_wb_valid <= 1'b1;
            o_wb_data  <= ext_data;
            o_wb_rd    <= rd_q;
            state      <= ST_RESP;
          end
        end
`endif
        ST_RESP, ST_ERR: state <= ST_IDLE;
        default:         state <= ST_IDLE;
      endcase
    end
  end

endmodule
